// File: rtl/myca_seq_pkg.sv
// myca_pkg: opcodes, FSM states and microword field helpers for the Myca microsequencer
package myca_pkg;

    typedef enum logic [2:0] {
        OP_CONT, OP_JMP, OP_JMPT, OP_JMPF, OP_CALL, OP_RET, OP_WAIT, OP_HALT
    } op_e;

    typedef enum logic [1:0] {
        S_WAIT, S_FETCH, S_EXEC, S_HALT
    } state_e;

    function automatic int fs_w(input int nflag);
        return $clog2(nflag) + 1;
    endfunction

    function automatic int uw_w(input int pc_w, input int nflag, input int nout);
        return 3 + fs_w(nflag) + pc_w + nout;
    endfunction

    function automatic int dir_lo(input int nout);
        return nout;
    endfunction

    function automatic int fs_lo(input int pc_w, input int nout);
        return nout + pc_w;
    endfunction

endpackage

// File: rtl/myca_seq_tick_div.sv
// myca_tick_div: free-running divider giving a registered 1-ck tick every DIV cycles
module myca_tick_div #(
    parameter int DIV = 1
) (
    input  logic ck,
    input  logic rst,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    logic          last;
    assign last = cnt == CW'(DIV - 1);
    // count 0..DIV-1 and pulse for the cycle after the terminal count
    always_ff @(posedge ck) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= last ? '0 : cnt + 1'b1;
            tick <= last;
        end
    end
endmodule

// File: rtl/myca_seq.sv
// myca_seq: microsequencer fetching microwords from a sync ROM; MYCA_SEQ_STACK_EN enables the call/return stack
module myca_seq
    import myca_pkg::*;
#(
    parameter  int PC_W    = 8,
    parameter  int NFLAG   = 8,
    parameter  int NOUT    = 4,
    parameter  int STACK_D = 4,
    parameter  int DIV     = 1,
    localparam int FS_W    = fs_w(NFLAG),
    localparam int UW      = uw_w(PC_W, NFLAG, NOUT)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [NFLAG-1:0] flags,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [UW-1:0]    rom_q,
    output logic [NOUT-1:0]  ctl,
    output logic [PC_W-1:0]  pc,
    output logic             tick,
    output logic             halted,
    output logic             err
);
    localparam int IW = FS_W - 1;

    state_e          st;
    op_e             op;
    logic [FS_W-1:0] fsel;
    logic [IW-1:0]   idx;
    logic            inv, x;
    logic [PC_W-1:0] dir, pc_inc, npc;
    logic [NOUT-1:0] out;
    logic            fault, stop;

    myca_tick_div #(.DIV(DIV)) u_div (.ck(ck), .rst(rst), .tick(tick));

    assign rom_addr = pc;
    assign op       = op_e'(rom_q[UW-1 -: 3]);
    assign fsel     = rom_q[fs_lo(PC_W, NOUT) +: FS_W];
    assign dir      = rom_q[dir_lo(NOUT) +: PC_W];
    assign out      = rom_q[NOUT-1:0];
    assign idx      = fsel[IW-1:0];
    assign inv      = fsel[FS_W-1];
    assign x        = ((int'(idx) < NFLAG) ? flags[idx] : 1'b0) ^ inv;
    assign pc_inc   = pc + 1'b1;
    assign stop     = (op == OP_HALT) | fault;

`ifdef MYCA_SEQ_STACK_EN
    localparam int SPW = $clog2(STACK_D + 1);
    logic [PC_W-1:0] stk [STACK_D];
    logic [PC_W-1:0] top;
    logic [SPW-1:0]  sp;
    logic            full, empty, push, pop;
    assign full  = sp == SPW'(STACK_D);
    assign empty = sp == '0;
    // top-of-stack entry is slot sp-1
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_D; i++)
            if (sp == SPW'(i + 1)) top = stk[i];
    end
`endif

    // next pc and stack action for the microword in EXEC
    always_comb begin
        npc   = pc_inc;
        fault = 1'b0;
`ifdef MYCA_SEQ_STACK_EN
        push  = 1'b0;
        pop   = 1'b0;
`endif
        case (op)
            OP_JMP:  npc = dir;
            OP_JMPT: npc = x ? dir : pc_inc;
            OP_JMPF: npc = x ? pc_inc : dir;
`ifdef MYCA_SEQ_STACK_EN
            OP_CALL: begin
                fault = full;
                push  = !full;
                npc   = full ? pc : dir;
            end
            OP_RET: begin
                fault = empty;
                pop   = !empty;
                npc   = empty ? pc : top;
            end
`else
            OP_CALL: npc = dir;
`endif
            OP_WAIT: npc = x ? pc_inc : pc;
            OP_HALT: npc = pc;
            default: npc = pc_inc;
        endcase
    end

`ifdef MYCA_SEQ_STACK_EN
    // LIFO: push writes slot sp, pop only drops the pointer
    always_ff @(posedge ck) begin
        if (rst) begin
            sp <= '0;
        end else if (st == S_EXEC) begin
            if (push) begin
                for (int i = 0; i < STACK_D; i++)
                    if (sp == SPW'(i)) stk[i] <= pc_inc;
                sp <= sp + 1'b1;
            end else if (pop) begin
                sp <= sp - 1'b1;
            end
        end
    end
`endif

    // sequencer FSM: wait for tick, fetch, execute; HALT is left only by reset
    always_ff @(posedge ck) begin
        if (rst) begin
            st     <= S_WAIT;
            pc     <= '0;
            ctl    <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (st)
                S_WAIT:  st <= tick ? S_FETCH : S_WAIT;
                S_FETCH: st <= S_EXEC;
                S_EXEC: begin
                    ctl    <= out;
                    pc     <= npc;
                    halted <= stop;
                    err    <= err | fault;
                    st     <= stop ? S_HALT : S_WAIT;
                end
                default: st <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_myca_seq.sv
// tb_myca_seq: directed checks of myca_seq (DIV=1 instance and DIV=4 instance)
module tb_myca_seq;
    import myca_pkg::*;
    localparam int UW = 19;

    logic          ck = 1'b0;
    logic          rst, rst_b;
    logic [7:0]    flags;
    logic [7:0]    rom_addr_a, pc_a, rom_addr_b, pc_b;
    logic [UW-1:0] rom_q_a, rom_q_b;
    logic [3:0]    ctl_a, ctl_b;
    logic          tick_a, halted_a, err_a, tick_b, halted_b, err_b;
    logic [UW-1:0] rom_a [256];
    logic [UW-1:0] rom_b [256];
    int            checks = 0;
    int            failures = 0;

    always #5 ck = ~ck;

    always @(posedge ck) rom_q_a <= rom_a[rom_addr_a];
    always @(posedge ck) rom_q_b <= rom_b[rom_addr_b];

    myca_seq #(.PC_W(8), .NFLAG(8), .NOUT(4), .STACK_D(2), .DIV(1)) dut_a (
        .ck(ck), .rst(rst), .flags(flags), .rom_addr(rom_addr_a), .rom_q(rom_q_a),
        .ctl(ctl_a), .pc(pc_a), .tick(tick_a), .halted(halted_a), .err(err_a)
    );

    myca_seq #(.PC_W(8), .NFLAG(8), .NOUT(4), .STACK_D(4), .DIV(4)) dut_b (
        .ck(ck), .rst(rst_b), .flags(flags), .rom_addr(rom_addr_b), .rom_q(rom_q_b),
        .ctl(ctl_b), .pc(pc_b), .tick(tick_b), .halted(halted_b), .err(err_b)
    );

    function automatic logic [UW-1:0] mw(input op_e op, input logic [3:0] fs,
                                         input logic [7:0] d, input logic [3:0] o);
        return {op, fs, d, o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_rst();
        rst = 1'b1;
        repeat (2) @(negedge ck);
    endtask

    task automatic rel();
        rst = 1'b0;
        repeat (4) @(posedge ck);
        @(negedge ck);
    endtask

    task automatic nxt();
        repeat (3) @(posedge ck);
        @(negedge ck);
    endtask

    initial begin
        rst   = 1'b1;
        rst_b = 1'b1;
        flags = '0;
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = '0;
            rom_b[i] = '0;
        end
        rom_a[0]     = mw(OP_CONT, 4'h0, 8'h00, 4'h1);
        rom_a[1]     = mw(OP_CONT, 4'h0, 8'h00, 4'h2);
        rom_a[2]     = mw(OP_JMP,  4'h0, 8'h00, 4'h3);
        rom_b[0]     = mw(OP_JMP,  4'h0, 8'hFE, 4'h1);
        rom_b[8'hFE] = mw(OP_CONT, 4'h0, 8'h00, 4'h2);
        rom_b[8'hFF] = mw(OP_CONT, 4'h0, 8'h00, 4'h3);
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("rst_ctl", 32'(ctl_a), 0);
        chk("rst_pc", 32'(pc_a), 0);
        chk("rst_halted", 32'(halted_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_tick", 32'(tick_a), 0);

        rel();
        chk("loop_ctl0", 32'(ctl_a), 1);
        chk("loop_pc0", 32'(pc_a), 1);
        nxt();
        chk("loop_ctl1", 32'(ctl_a), 2);
        chk("loop_pc1", 32'(pc_a), 2);
        nxt();
        chk("loop_ctl2", 32'(ctl_a), 3);
        chk("loop_pc2", 32'(pc_a), 0);
        nxt();
        chk("loop_ctl3", 32'(ctl_a), 1);
        chk("loop_pc3", 32'(pc_a), 1);

        hold_rst();
        flags        = 8'h08;
        rom_a[0]     = mw(OP_JMPT, 4'h3, 8'h20, 4'h5);
        rom_a[8'h20] = mw(OP_JMPT, 4'hB, 8'h40, 4'h6);
        rom_a[8'h21] = mw(OP_JMPF, 4'h4, 8'h30, 4'h7);
        rom_a[8'h30] = mw(OP_WAIT, 4'h0, 8'h00, 4'h8);
        rom_a[8'h31] = mw(OP_HALT, 4'h0, 8'h00, 4'h9);
        rel();
        chk("jmpt_taken_pc", 32'(pc_a), 'h20);
        chk("jmpt_taken_ctl", 32'(ctl_a), 5);
        nxt();
        chk("jmpt_inv_pc", 32'(pc_a), 'h21);
        chk("jmpt_inv_ctl", 32'(ctl_a), 6);
        nxt();
        chk("jmpf_pc", 32'(pc_a), 'h30);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("wait_hold_pc", 32'(pc_a), 'h30);
            chk("wait_hold_ctl", 32'(ctl_a), 8);
        end
        flags[0] = 1'b1;
        nxt();
        chk("wait_go_pc", 32'(pc_a), 'h31);
        nxt();
        chk("halt_ctl", 32'(ctl_a), 9);
        chk("halt_pc", 32'(pc_a), 'h31);
        chk("halt_halted", 32'(halted_a), 1);
        chk("halt_err", 32'(err_a), 0);
        nxt();
        chk("halt_frozen_ctl", 32'(ctl_a), 9);
        chk("halt_frozen_pc", 32'(pc_a), 'h31);
        chk("halt_tick_runs", 32'(tick_a), 1);

        hold_rst();
        flags = '0;
`ifdef MYCA_SEQ_STACK_EN
        rom_a[0]     = mw(OP_CALL, 4'h0, 8'h10, 4'h1);
        rom_a[8'h10] = mw(OP_CALL, 4'h0, 8'h20, 4'h2);
        rom_a[8'h20] = mw(OP_RET,  4'h0, 8'h00, 4'h3);
        rom_a[8'h11] = mw(OP_RET,  4'h0, 8'h00, 4'h4);
        rom_a[8'h01] = mw(OP_CALL, 4'h0, 8'h50, 4'h5);
        rom_a[8'h50] = mw(OP_CALL, 4'h0, 8'h60, 4'h6);
        rom_a[8'h60] = mw(OP_CALL, 4'h0, 8'h70, 4'h6);
        rel();
        chk("call1_pc", 32'(pc_a), 'h10);
        nxt();
        chk("call2_pc", 32'(pc_a), 'h20);
        nxt();
        chk("ret1_pc", 32'(pc_a), 'h11);
        chk("ret1_ctl", 32'(ctl_a), 3);
        nxt();
        chk("ret2_pc", 32'(pc_a), 'h01);
        chk("ret2_err", 32'(err_a), 0);
        nxt();
        chk("call3_pc", 32'(pc_a), 'h50);
        nxt();
        chk("call4_pc", 32'(pc_a), 'h60);
        chk("call4_halted", 32'(halted_a), 0);
        nxt();
        chk("ovf_err", 32'(err_a), 1);
        chk("ovf_halted", 32'(halted_a), 1);
        chk("ovf_ctl", 32'(ctl_a), 6);
        nxt();
        chk("ovf_frozen_ctl", 32'(ctl_a), 6);
        chk("ovf_frozen_err", 32'(err_a), 1);
        hold_rst();
        rom_a[0] = mw(OP_RET, 4'h0, 8'h00, 4'h3);
        rel();
        chk("unf_err", 32'(err_a), 1);
        chk("unf_halted", 32'(halted_a), 1);
`else
        rom_a[0]     = mw(OP_CALL, 4'h0, 8'h10, 4'h1);
        rom_a[8'h10] = mw(OP_RET,  4'h0, 8'h00, 4'h2);
        rom_a[8'h11] = mw(OP_HALT, 4'h0, 8'h00, 4'h4);
        rel();
        chk("call_as_jmp_pc", 32'(pc_a), 'h10);
        nxt();
        chk("ret_as_cont_pc", 32'(pc_a), 'h11);
        chk("ret_as_cont_err", 32'(err_a), 0);
        chk("ret_as_cont_halted", 32'(halted_a), 0);
`endif
        hold_rst();
        chk("rst2_ctl", 32'(ctl_a), 0);
        chk("rst2_pc", 32'(pc_a), 0);
        chk("rst2_halted", 32'(halted_a), 0);
        chk("rst2_err", 32'(err_a), 0);

        rst_b = 1'b0;
        for (int i = 0; i < 100 && pc_b !== 8'hFF; i++) @(negedge ck);
        chk("div4_reach_ff", 32'(pc_b), 'hFF);
        for (int i = 0; i < 100 && pc_b !== 8'h00; i++) @(negedge ck);
        chk("div4_wrap_pc", 32'(pc_b), 0);
        chk("div4_wrap_ctl", 32'(ctl_b), 3);
        begin
            int last;
            int n;
            last = -1;
            n    = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge ck);
                if (tick_b) begin
                    if (last >= 0) chk("div4_tick_gap", 32'(i - last), 4);
                    last = i;
                    n++;
                end
            end
            chk("div4_tick_count", 32'(n), 4);
        end
        for (int i = 0; i < 100 && !(pc_b === 8'hFE && tick_b === 1'b1); i++) @(negedge ck);
        chk("div4_fe_tick", 32'({pc_b, tick_b}), 'h1FD);
        @(negedge ck);
        rst_b = 1'b1;
        @(posedge ck);
        @(negedge ck);
        chk("div4_fetch_rst_pc", 32'(pc_b), 0);
        chk("div4_fetch_rst_ctl", 32'(ctl_b), 0);
        chk("div4_fetch_rst_halted", 32'(halted_b), 0);
        chk("div4_fetch_rst_err", 32'(err_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
